// File: rtl/vgpr_port_arb.sv
// Shares one VGPR read/write port set among NUM_REQ requesters: a round-robin read FSM
// (one read in flight) and an independent round-robin 1-entry write stage.
module vgpr_port_arb #(
  parameter int NUM_REQ    = 2,
  parameter int RD_PORTS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQ-1:0]                         rd_req_valid,
  output logic [NUM_REQ-1:0]                         rd_req_ready,
  input  logic [NUM_REQ-1:0][RD_PORTS-1:0][AW-1:0]   rd_req_addr,
  input  logic [NUM_REQ-1:0][RD_PORTS-1:0]           rd_req_mask,
  output logic [NUM_REQ-1:0]                         rd_resp_valid,
  input  logic [NUM_REQ-1:0]                         rd_resp_ready,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]        rd_resp_hi,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]        rd_resp_lo,
  input  logic [NUM_REQ-1:0]                         wr_req_valid,
  output logic [NUM_REQ-1:0]                         wr_req_ready,
  input  logic [NUM_REQ-1:0][AW-1:0]                 wr_req_addr,
  input  logic [NUM_REQ-1:0][2*DATA_WIDTH-1:0]       wr_req_data,
  input  logic [NUM_REQ-1:0][1:0]                    wr_req_strb,
  output logic [RD_PORTS-1:0][AW-1:0]                raddr,
  output logic [RD_PORTS-1:0]                        renable,
  output logic [AW-1:0]                              waddr,
  output logic [2*DATA_WIDTH-1:0]                    wdata,
  output logic [1:0]                                 wstrb,
  output logic                                       wenable,
  input  logic [RD_PORTS-1:0][DATA_WIDTH-1:0]        rdata_hi,
  input  logic [RD_PORTS-1:0][DATA_WIDTH-1:0]        rdata_lo,
  input  logic                                       vgpr_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} rd_state_e;

  rd_state_e state_r, state_s;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r, lat_req_r;
  logic [RD_PORTS-1:0] mask_r;
  logic [PW:0] rd_pick_s, wr_pick_s;
  logic [PW-1:0] rd_gnt_s, wr_gnt_s;
  logic rd_accept_s, rd_done_s, rd_hs_s, wr_accept_s;
  logic [RD_PORTS-1:0][DATA_WIDTH-1:0] rsp_hi_s, rsp_lo_s;

  // Returns {found, index} of the first asserted request at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [PW-1:0] ptr);
    logic found;
    logic [PW-1:0] idx, cand;
    int j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j    = int'(ptr) + i;
      j    = (j >= NUM_REQ) ? j - NUM_REQ : j;
      cand = PW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return (int'(g) + 1 >= NUM_REQ) ? PW'(0) : g + PW'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] g);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  assign rd_pick_s = rr_pick(rd_req_valid, rd_ptr_r);
  assign wr_pick_s = rr_pick(wr_req_valid, wr_ptr_r);
  assign rd_gnt_s  = rd_pick_s[PW-1:0];
  assign wr_gnt_s  = wr_pick_s[PW-1:0];

  // Read FSM next state; reads wait for an empty write stage so writes land first.
  always_comb begin
    state_s     = state_r;
    rd_accept_s = 1'b0;
    rd_done_s   = 1'b0;
    rd_hs_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!reset && rd_pick_s[PW] && !wenable) begin
          rd_accept_s = 1'b1;
          state_s     = (|rd_req_mask[rd_gnt_s]) ? ISSUE : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (vgpr_done) begin
          rd_done_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = ISSUE;
        end
      end
      RESP: begin
        if (rd_resp_ready[lat_req_r]) begin
          rd_hs_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Grant pulses and mask-gated response lanes.
  always_comb begin
    rd_req_ready = '0;
    wr_req_ready = '0;
    wr_accept_s  = !reset && wr_pick_s[PW];
    if (rd_accept_s) begin
      rd_req_ready = onehot(rd_gnt_s);
    end else begin
      rd_req_ready = '0;
    end
    if (wr_accept_s) begin
      wr_req_ready = onehot(wr_gnt_s);
    end else begin
      wr_req_ready = '0;
    end
    for (int l = 0; l < RD_PORTS; l++) begin
      rsp_hi_s[l] = mask_r[l] ? rdata_hi[l] : '0;
      rsp_lo_s[l] = mask_r[l] ? rdata_lo[l] : '0;
    end
  end

  // State, read payload/response and write stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      lat_req_r     <= '0;
      mask_r        <= '0;
      raddr         <= '0;
      renable       <= '0;
      rd_resp_valid <= '0;
      rd_resp_hi    <= '0;
      rd_resp_lo    <= '0;
      waddr         <= '0;
      wdata         <= '0;
      wstrb         <= 2'b00;
      wenable       <= 1'b0;
    end else begin
      state_r <= state_s;
      if (rd_accept_s) begin
        lat_req_r <= rd_gnt_s;
        mask_r    <= rd_req_mask[rd_gnt_s];
        rd_ptr_r  <= next_ptr(rd_gnt_s);
        if (|rd_req_mask[rd_gnt_s]) begin
          raddr   <= rd_req_addr[rd_gnt_s];
          renable <= rd_req_mask[rd_gnt_s];
        end else begin
          // Empty mask: the VGPR never answers, so respond immediately with zeros.
          rd_resp_valid <= onehot(rd_gnt_s);
          rd_resp_hi    <= '0;
          rd_resp_lo    <= '0;
        end
      end else if (rd_done_s) begin
        renable       <= '0;
        rd_resp_hi    <= rsp_hi_s;
        rd_resp_lo    <= rsp_lo_s;
        rd_resp_valid <= onehot(lat_req_r);
      end else if (rd_hs_s) begin
        rd_resp_valid <= '0;
      end
      wenable <= wr_accept_s;
      if (wr_accept_s) begin
        waddr    <= wr_req_addr[wr_gnt_s];
        wdata    <= wr_req_data[wr_gnt_s];
        wstrb    <= wr_req_strb[wr_gnt_s];
        wr_ptr_r <= next_ptr(wr_gnt_s);
      end
    end
  end

endmodule

// File: tb/tb_vgpr_port_arb.sv
// Directed bench for vgpr_port_arb: read latency, masking, arbitration, write ordering,
// back-pressure, back-to-back writes and mid-transaction reset.
module tb_vgpr_port_arb;
  localparam int NR = 2, RP = 4, DW = 32, DEPTH = 256, AW = 8;

  logic clk, reset;
  logic [NR-1:0] rd_req_valid, rd_req_ready, rd_resp_valid, rd_resp_ready;
  logic [NR-1:0][RP-1:0][AW-1:0] rd_req_addr;
  logic [NR-1:0][RP-1:0] rd_req_mask;
  logic [RP-1:0][DW-1:0] rd_resp_hi, rd_resp_lo, rdata_hi, rdata_lo;
  logic [NR-1:0] wr_req_valid, wr_req_ready;
  logic [NR-1:0][AW-1:0] wr_req_addr;
  logic [NR-1:0][2*DW-1:0] wr_req_data;
  logic [NR-1:0][1:0] wr_req_strb;
  logic [RP-1:0][AW-1:0] raddr;
  logic [RP-1:0] renable;
  logic [AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic [1:0] wstrb;
  logic wenable, vgpr_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NR-1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  vgpr_port_arb #(.NUM_REQ(NR), .RD_PORTS(RP), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_mask(rd_req_mask),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_hi(rd_resp_hi), .rd_resp_lo(rd_resp_lo),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
    .raddr(raddr), .renable(renable), .waddr(waddr), .wdata(wdata),
    .wstrb(wstrb), .wenable(wenable),
    .rdata_hi(rdata_hi), .rdata_lo(rdata_lo), .vgpr_done(vgpr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VGPR stand-in: lane data derived from its address (addr 0..3 -> 0x11..0x44).
  always_comb begin
    for (int l = 0; l < RP; l++) begin
      rdata_lo[l] = 32'h11 * (32'(raddr[l]) + 32'd1);
      rdata_hi[l] = rdata_lo[l] ^ 32'hA5A5_0000;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; vgpr_done = 1'b0;
    rd_req_valid = 2'b11; rd_resp_ready = 2'b00; rd_req_addr = '0; rd_req_mask = '0;
    wr_req_valid = 2'b11; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
    repeat (2) tick();
    #1;
    check("rst_rd_ready", 128'(rd_req_ready), 128'(2'b00));
    check("rst_wr_ready", 128'(wr_req_ready), 128'(2'b00));
    check("rst_renable", 128'(renable), 128'(4'h0));
    check("rst_wenable", 128'(wenable), 128'(1'b0));
    check("rst_resp_valid", 128'(rd_resp_valid), 128'(2'b00));
    check("rst_raddr", 128'(raddr), 128'(32'h0));
    check("rst_resp_lo", 128'(rd_resp_lo), 128'h0);
    rd_req_valid = 2'b00; wr_req_valid = 2'b00; reset = 1'b0;
    tick();

    // Full-mask read from requester 0
    rd_req_addr[0] = {8'd3, 8'd2, 8'd1, 8'd0}; rd_req_mask[0] = 4'hF; rd_req_valid = 2'b01;
    #1 check("r0_ready", 128'(rd_req_ready), 128'(2'b01));
    tick(); rd_req_valid = 2'b00;
    check("r0_renable_p1", 128'(renable), 128'(4'hF));
    check("r0_raddr", 128'(raddr), 128'(32'h03020100));
    tick();
    check("r0_renable_p2", 128'(renable), 128'(4'hF));
    check("r0_no_resp_yet", 128'(rd_resp_valid), 128'(2'b00));
    vgpr_done = 1'b1; tick(); vgpr_done = 1'b0;
    check("r0_renable_off", 128'(renable), 128'(4'h0));
    check("r0_resp_valid", 128'(rd_resp_valid), 128'(2'b01));
    check("r0_lo_lane0", 128'(rd_resp_lo[0]), 128'(32'h11));
    check("r0_lo_all", 128'(rd_resp_lo), 128'h00000044_00000033_00000022_00000011);
    check("r0_hi_lane1", 128'(rd_resp_hi[1]), 128'(32'hA5A5_0022));
    rd_resp_ready = 2'b01; tick(); rd_resp_ready = 2'b00;
    check("r0_resp_clr", 128'(rd_resp_valid), 128'(2'b00));

    // Empty-mask read from requester 1 (pointer now at 1)
    rd_req_addr[1] = {8'd7, 8'd6, 8'd5, 8'd4}; rd_req_mask[1] = 4'h0; rd_req_valid = 2'b10;
    #1 check("m0_ready", 128'(rd_req_ready), 128'(2'b10));
    tick(); rd_req_valid = 2'b00;
    check("m0_resp_valid", 128'(rd_resp_valid), 128'(2'b10));
    check("m0_renable", 128'(renable), 128'(4'h0));
    check("m0_lo", 128'(rd_resp_lo), 128'h0);
    check("m0_hi", 128'(rd_resp_hi), 128'h0);
    rd_resp_ready = 2'b10; tick(); rd_resp_ready = 2'b00;

    // Partial mask with response back-pressure for 10 cycles
    rd_req_mask[0] = 4'b0101; rd_req_valid = 2'b01;
    tick(); rd_req_valid = 2'b00;
    check("bp_renable", 128'(renable), 128'(4'b0101));
    vgpr_done = 1'b1; tick(); vgpr_done = 1'b0;
    rd_req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_lo", 128'(rd_resp_lo), 128'h00000000_00000033_00000000_00000011);
      check("bp_valid", 128'(rd_resp_valid), 128'(2'b01));
      check("bp_rd_ready", 128'(rd_req_ready), 128'(2'b00));
      check("bp_renable0", 128'(renable), 128'(4'h0));
      tick();
    end
    rd_req_valid = 2'b00; rd_resp_ready = 2'b01; tick(); rd_resp_ready = 2'b00;

    // Fairness from a fresh reset: both requesters continuously requesting
    reset = 1'b1; tick(); reset = 1'b0; tick();
    rd_req_mask = '0; rd_req_valid = 2'b11; rd_resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      #1;
      while (rd_req_ready == 2'b00 && n < 8) begin
        tick(); #1; n++;
      end
      check("rr_grant", 128'(rd_req_ready), 128'(exp_gnt[k]));
      tick();
    end
    rd_req_valid = 2'b00; tick(); tick(); rd_resp_ready = 2'b00;

    // Write pending in the stage holds off a read for one cycle
    wr_req_addr[0] = 8'd5; wr_req_data[0] = 64'hDEAD_BEEF_0123_4567; wr_req_strb[0] = 2'b11;
    wr_req_valid = 2'b01;
    #1 check("w_ready", 128'(wr_req_ready), 128'(2'b01));
    tick(); wr_req_valid = 2'b00;
    rd_req_addr[0] = {8'd3, 8'd2, 8'd1, 8'd0}; rd_req_mask[0] = 4'hF; rd_req_valid = 2'b01;
    #1;
    check("w_wenable", 128'(wenable), 128'(1'b1));
    check("w_waddr", 128'(waddr), 128'(8'd5));
    check("w_wdata", 128'(wdata), 128'(64'hDEAD_BEEF_0123_4567));
    check("w_wstrb", 128'(wstrb), 128'(2'b11));
    check("w_rd_blocked", 128'(rd_req_ready), 128'(2'b00));
    tick(); #1;
    check("w_wenable_off", 128'(wenable), 128'(1'b0));
    check("w_rd_accept", 128'(rd_req_ready), 128'(2'b01));
    tick(); rd_req_valid = 2'b00;
    check("w_rd_renable", 128'(renable), 128'(4'hF));
    vgpr_done = 1'b1; tick(); vgpr_done = 1'b0;
    rd_resp_ready = 2'b01; tick(); rd_resp_ready = 2'b00;

    // Back-to-back writes, write pointer now at 1
    wr_req_addr[1] = 8'd9; wr_req_data[1] = 64'h0000_0000_CAFE_F00D; wr_req_strb[1] = 2'b01;
    wr_req_valid = 2'b11;
    #1 check("bb_ready1", 128'(wr_req_ready), 128'(2'b10));
    tick();
    check("bb_waddr1", 128'(waddr), 128'(8'd9));
    check("bb_wstrb1", 128'(wstrb), 128'(2'b01));
    check("bb_ready0", 128'(wr_req_ready), 128'(2'b01));
    tick(); wr_req_valid = 2'b00;
    check("bb_wenable2", 128'(wenable), 128'(1'b1));
    check("bb_waddr0", 128'(waddr), 128'(8'd5));
    tick();
    check("bb_idle", 128'(wenable), 128'(1'b0));

    // Reset two cycles into ISSUE abandons the read
    rd_req_addr[1] = {8'd13, 8'd12, 8'd11, 8'd10}; rd_req_mask[1] = 4'hF; rd_req_valid = 2'b10;
    #1 check("ab_ready", 128'(rd_req_ready), 128'(2'b10));
    tick(); rd_req_valid = 2'b00;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("ab_renable", 128'(renable), 128'(4'h0));
    check("ab_raddr", 128'(raddr), 128'(32'h0));
    check("ab_resp_valid", 128'(rd_resp_valid), 128'(2'b00));
    check("ab_resp_lo", 128'(rd_resp_lo), 128'h0);
    check("ab_resp_hi", 128'(rd_resp_hi), 128'h0);
    vgpr_done = 1'b1; tick(); vgpr_done = 1'b0;
    check("ab_no_resp1", 128'(rd_resp_valid), 128'(2'b00));
    tick();
    check("ab_no_resp2", 128'(rd_resp_valid), 128'(2'b00));
    check("ab_renable2", 128'(renable), 128'(4'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vgpr_port_arb.md
VGPR_PORT_ARB -- requirements
Module: vgpr_port_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing one VGPR read/write port set.
REQ-002 SHALL have parameter RD_PORTS, default 4: read threads per request, matching the VGPR instance.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: register width.
REQ-004 SHALL have parameter DEPTH, default 256: register count. AW = $clog2(DEPTH).
REQ-005 SHALL have port `clk`, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports `rd_req_valid` and `rd_req_ready`: input and output, NUM_REQ bits each, per-requester read handshake.
REQ-008 SHALL have ports `rd_req_addr` (input, NUM_REQ x RD_PORTS x AW) and `rd_req_mask` (input, NUM_REQ x RD_PORTS): per-requester read payload.
REQ-009 SHALL have ports `rd_resp_valid` (output, NUM_REQ) and `rd_resp_ready` (input, NUM_REQ): per-requester response handshake.
REQ-010 SHALL have ports `rd_resp_hi` and `rd_resp_lo`: outputs, RD_PORTS x DATA_WIDTH each, shared by all requesters.
REQ-011 SHALL have ports `wr_req_valid` (input, NUM_REQ), `wr_req_ready` (output, NUM_REQ), `wr_req_addr` (NUM_REQ x AW), `wr_req_data` (NUM_REQ x 2*DATA_WIDTH) and `wr_req_strb` (NUM_REQ x 2).
REQ-012 SHALL have VGPR-side outputs `raddr` (RD_PORTS x AW), `renable` (RD_PORTS), `waddr` (AW), `wdata` (2*DATA_WIDTH), `wstrb` (2) and `wenable` (1).
REQ-013 SHALL have VGPR-side inputs `rdata_hi` and `rdata_lo` (RD_PORTS x DATA_WIDTH each) and `vgpr_done` (1).

Function
REQ-014 SHALL implement the read FSM with states IDLE, ISSUE, RESP.
REQ-015 In IDLE, SHALL grant a read round-robin among asserted `rd_req_valid` bits, searching from last read grantee + 1. After reset the search starts at requester 0.
REQ-016 In IDLE, SHALL accept a read only while the write stage is empty (`wenable`=0), so an earlier write always precedes a later read.
REQ-017 On acceptance, SHALL pulse `rd_req_ready[g]` for 1 cycle, combinationally, in the accept cycle. Address and mask SHALL be latched.
REQ-018 If the latched mask is nonzero, SHALL go to ISSUE. From the next cycle, `raddr` and `renable` SHALL be registered copies of the latched payload, held stable.
REQ-019 In ISSUE, on the cycle `vgpr_done`=1, SHALL capture `rdata_hi`/`rdata_lo` into the response registers.
REQ-020 On that same `vgpr_done` cycle, SHALL clear `renable` to 0 at the same edge and go to RESP. `renable` SHALL never remain high in the cycle after `vgpr_done`.
REQ-021 If the latched mask is zero, SHALL go directly to RESP with zeroed response data. The VGPR SHALL NOT be driven, because it never signals done for an empty mask.
REQ-022 Response lanes with mask bit 0 SHALL read as zero.
REQ-023 In RESP, `rd_resp_valid[g]` SHALL be 1 and all other bits 0. Data SHALL be stable until `rd_resp_ready[g]`=1.
REQ-024 On response handshake, SHALL return to IDLE. A new read SHALL NOT be accepted in the handshake cycle, giving at most one read in flight.
REQ-025 Read latency SHALL be: accept -> `renable` at +1 -> `vgpr_done` at VGPR-dependent cycle D -> `rd_resp_valid` at D+1.
REQ-026 The write path SHALL be independent of the read FSM: a 1-entry stage, granted round-robin with its own pointer.
REQ-027 A write SHALL be accepted when the stage is empty, or draining this cycle.
REQ-028 Each accepted write SHALL be presented on `waddr`/`wdata`/`wstrb` with `wenable`=1 for exactly 1 cycle, the cycle after acceptance. This gives back-to-back writes at 1 per cycle.
REQ-029 `vgpr_done` outside ISSUE SHALL be ignored.
REQ-030 `rd_req_valid` dropping before its grant SHALL be legal and cause no grant.
REQ-031 Simultaneous read accept and write accept from the same requester SHALL be legal when REQ-016 permits.

Reset
REQ-032 While `reset`=1, SHALL drive the read FSM to IDLE, clear both round-robin pointers to requester 0, and empty the write stage.
REQ-033 While `reset`=1, SHALL hold all `*_ready`, `rd_resp_valid`, `renable` and `wenable` at 0, and hold `raddr`, `waddr`, `wdata`, `wstrb`, `rd_resp_hi` and `rd_resp_lo` at 0.
REQ-034 Reset asserted mid-ISSUE or mid-RESP SHALL abandon the transaction, with no response delivered.

Verification
REQ-035 Requester 0 read, mask 4'b1111, addresses 0,1,2,3, VGPR model returns 0x11..0x44 -> `renable`=4'hF from accept+1 until done. `rd_resp_valid`=2'b01 on the cycle after `vgpr_done`. `rd_resp_lo` lane 0 = 0x11.
REQ-036 Both requesters hold `rd_req_valid` continuously for 4 reads -> grants alternate 0,1,0,1, and no requester receives two grants in a row.
REQ-037 Read with mask 4'b0000 -> `renable` stays 0. `rd_resp_valid` is 1 one cycle after accept. Data is 0.
REQ-038 Write to address 5 is pending in the stage in the same cycle a read request arrives -> the read is accepted only after the `wenable` cycle.
REQ-039 `rd_resp_ready` held low for 10 cycles in RESP -> response is stable, `rd_req_ready` stays 0 throughout, and `renable` stays 0.
REQ-040 Reset asserted 2 cycles into ISSUE -> next cycle all outputs are 0. A subsequent `vgpr_done` pulse produces no response.
